// File: rtl/imm_pkg.sv
// Shared immediate-format types, RV opcodes and the XLEN legality check.
// Pure declarations; no timing or flow control lives here.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_type_e;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and sign extension to XLEN.
// Zero latency; no flow control. Unknown type encodings raise o_illegal.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_type,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    logic [31:0] w_imm32;
    logic        w_unused_opc;

    assign w_unused_opc = ^i_instr[6:0];

    always_comb begin
        w_imm32   = '0;
        o_illegal = 1'b0;
        case (i_type)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
            default: o_illegal = 1'b1;
        endcase
    end

    // Every format is sign-extended from bit 31, so RV64 matches RV32 in the low word.
    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode, extract, then a 2-entry output/skid buffer.
// Latency 1 cycle; in_ready is registered (skid entry empty), holds output under backpressure.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);

    generate
        if (!xlen_legal(XLEN)) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [2:0]      w_dec_type;
    logic            w_dec_bad;
    logic [XLEN-1:0] w_ext_imm;
    logic            w_ext_ill;
    logic            w_new_ill;
    logic [XLEN-1:0] w_new_imm;
    logic [2:0]      w_new_type;
    logic            w_acc;
    logic            w_drain;
    logic            w_r0_load;

    logic            r_r0_vld;
    logic [XLEN-1:0] r_r0_imm;
    logic [2:0]      r_r0_type;
    logic            r_r0_ill;
    logic            r_r1_vld;
    logic [XLEN-1:0] r_r1_imm;
    logic [2:0]      r_r1_type;
    logic            r_r1_ill;

    always_comb begin
        w_dec_type = imm_src;
        w_dec_bad  = 1'b0;
        if (AUTO_DECODE) begin
            case (instr[6:0])
                OP_IMM, LOAD, JALR, OP_IMM32: w_dec_type = IMM_I;
                STORE:                        w_dec_type = IMM_S;
                BRANCH:                       w_dec_type = IMM_B;
                JAL:                          w_dec_type = IMM_J;
                LUI, AUIPC:                   w_dec_type = IMM_U;
                default: begin
                    w_dec_type = IMM_I;
                    w_dec_bad  = 1'b1;
                end
            endcase
        end
    end

    imm_extract #(.XLEN(XLEN)) u_extract (
        .i_instr   (instr),
        .i_type    (w_dec_type),
        .o_imm     (w_ext_imm),
        .o_illegal (w_ext_ill)
    );

    // Illegal entries still flow, but carry a zero immediate and type I.
    assign w_new_ill  = w_dec_bad | w_ext_ill;
    assign w_new_imm  = w_new_ill ? '0 : w_ext_imm;
    assign w_new_type = w_new_ill ? IMM_I : w_dec_type;

    assign in_ready    = ~r_r1_vld;
    assign out_valid   = r_r0_vld;
    assign out_imm     = r_r0_imm;
    assign out_type    = r_r0_type;
    assign out_illegal = r_r0_ill;

    assign w_acc     = in_valid & in_ready;
    assign w_drain   = r_r0_vld & out_ready;
    assign w_r0_load = ~r_r0_vld | w_drain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r0_vld  <= 1'b0;
            r_r0_imm  <= '0;
            r_r0_type <= IMM_I;
            r_r0_ill  <= 1'b0;
            r_r1_vld  <= 1'b0;
            r_r1_imm  <= '0;
            r_r1_type <= IMM_I;
            r_r1_ill  <= 1'b0;
        end else if (flush) begin
            r_r0_vld <= 1'b0;
            r_r1_vld <= 1'b0;
        end else if (w_r0_load) begin
            // R1 is only ever full while R0 is full, so it refills R0 first.
            if (r_r1_vld) begin
                r_r0_vld  <= 1'b1;
                r_r0_imm  <= r_r1_imm;
                r_r0_type <= r_r1_type;
                r_r0_ill  <= r_r1_ill;
                r_r1_vld  <= 1'b0;
            end else begin
                r_r0_vld <= w_acc;
                if (w_acc) begin
                    r_r0_imm  <= w_new_imm;
                    r_r0_type <= w_new_type;
                    r_r0_ill  <= w_new_ill;
                end
            end
        end else if (w_acc) begin
            r_r1_vld  <= 1'b1;
            r_r1_imm  <= w_new_imm;
            r_r1_type <= w_new_type;
            r_r1_ill  <= w_new_ill;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: RV32 auto, RV32 external-format and RV64 auto instances
// driven by shared stimulus, checked with immediate assertions.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  imm_src;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm;
    logic [2:0]  a_out_type;
    logic        m_in_ready, m_out_valid, m_out_illegal;
    logic [31:0] m_out_imm;
    logic [2:0]  m_out_type;
    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [63:0] w_out_imm;
    logic [2:0]  w_out_type;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] s_instr [4] = '{32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF};
    logic [31:0] s_imm   [4] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
    logic [2:0]  s_type  [4] = '{3'b001, 3'b010, 3'b100, 3'b011};

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_type(a_out_type), .out_illegal(a_out_illegal)
    );

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_imm(m_out_imm), .out_type(m_out_type), .out_illegal(m_out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
        .instr(instr), .imm_src(imm_src), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_imm(w_out_imm), .out_type(w_out_type), .out_illegal(w_out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt = chk_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = 32'h0;
        imm_src   = 3'b000;
        #12;
        chk("rst_valid", 64'(a_out_valid), 64'd0);
        chk("rst_imm", 64'(a_out_imm), 64'd0);
        chk("rst_type", 64'(a_out_type), 64'd0);
        chk("rst_ill", 64'(a_out_illegal), 64'd0);
        chk("rst_imm64", w_out_imm, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_valid_after", 64'(a_out_valid), 64'd0);

        // addi x1,x0,-1 with a one-cycle latency
        in_valid = 1'b1;
        instr    = 32'hFFF00093;
        imm_src  = 3'b000;
        tick();
        in_valid = 1'b0;
        chk("addi_valid", 64'(a_out_valid), 64'd1);
        chk("addi_imm", 64'(a_out_imm), 64'hFFFFFFFF);
        chk("addi_type", 64'(a_out_type), 64'd0);
        chk("addi_ill", 64'(a_out_illegal), 64'd0);
        chk("addi_imm_man", 64'(m_out_imm), 64'hFFFFFFFF);
        chk("addi_imm64", w_out_imm, 64'hFFFFFFFFFFFFFFFF);
        tick();
        chk("addi_gone", 64'(a_out_valid), 64'd0);

        // back-to-back stream, external format mirrors the opcode
        in_valid = 1'b1;
        instr    = s_instr[0];
        imm_src  = s_type[0];
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("strm%0d_valid", i), 64'(a_out_valid), 64'd1);
            chk($sformatf("strm%0d_imm", i), 64'(a_out_imm), 64'(s_imm[i]));
            chk($sformatf("strm%0d_type", i), 64'(a_out_type), 64'(s_type[i]));
            chk($sformatf("strm%0d_imm_man", i), 64'(m_out_imm), 64'(s_imm[i]));
            chk($sformatf("strm%0d_rdy", i), 64'(a_in_ready), 64'd1);
            if (i < 3) begin
                instr   = s_instr[i + 1];
                imm_src = s_type[i + 1];
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
        chk("strm_end_valid", 64'(a_out_valid), 64'd0);

        // backpressure: three offered, two held, then ordered drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hFFF00093;
        imm_src   = 3'b000;
        tick();
        chk("bp_first_valid", 64'(a_out_valid), 64'd1);
        chk("bp_first_rdy", 64'(a_in_ready), 64'd1);
        instr = 32'hFE112E23;
        tick();
        chk("bp_full_rdy", 64'(a_in_ready), 64'd0);
        chk("bp_hold_imm", 64'(a_out_imm), 64'hFFFFFFFF);
        instr = 32'h123452B7;
        tick();
        chk("bp_still_full", 64'(a_in_ready), 64'd0);
        chk("bp_still_imm", 64'(a_out_imm), 64'hFFFFFFFF);
        chk("bp_still_type", 64'(a_out_type), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_drain1_imm", 64'(a_out_imm), 64'hFFFFFFFC);
        chk("bp_drain1_rdy", 64'(a_in_ready), 64'd1);
        tick();
        chk("bp_drain2_imm", 64'(a_out_imm), 64'h12345000);
        chk("bp_drain2_type", 64'(a_out_type), 64'd4);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 64'(a_out_valid), 64'd0);

        // unmapped opcode and illegal external format
        in_valid = 1'b1;
        instr    = 32'h0000007F;
        imm_src  = 3'b110;
        tick();
        in_valid = 1'b0;
        chk("ill_valid", 64'(a_out_valid), 64'd1);
        chk("ill_flag", 64'(a_out_illegal), 64'd1);
        chk("ill_imm", 64'(a_out_imm), 64'd0);
        chk("ill_type", 64'(a_out_type), 64'd0);
        chk("ill_man_flag", 64'(m_out_illegal), 64'd1);
        chk("ill_man_imm", 64'(m_out_imm), 64'd0);

        // lui with bit 31 set: RV64 sign-extends from bit 31
        in_valid = 1'b1;
        instr    = 32'h800002B7;
        imm_src  = 3'b100;
        tick();
        in_valid = 1'b0;
        chk("lui64_imm", w_out_imm, 64'hFFFFFFFF80000000);
        chk("lui64_type", 64'(w_out_type), 64'd4);
        chk("lui32_imm", 64'(a_out_imm), 64'h80000000);
        tick();

        // flush with two entries buffered and a new instruction offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hFFF00093;
        imm_src   = 3'b000;
        tick();
        instr = 32'hFE112E23;
        tick();
        chk("fl_full_rdy", 64'(a_in_ready), 64'd0);
        flush = 1'b1;
        instr = 32'h123452B7;
        tick();
        chk("fl_valid", 64'(a_out_valid), 64'd0);
        chk("fl_rdy", 64'(a_in_ready), 64'd1);
        // flush beats an accept that would otherwise succeed
        instr = 32'hFFF00093;
        tick();
        chk("fl_acc_dropped", 64'(a_out_valid), 64'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_nothing_out", 64'(a_out_valid), 64'd0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hFE000CE3;
        tick();
        in_valid = 1'b0;
        chk("ar_pre_valid", 64'(a_out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(a_out_valid), 64'd0);
        chk("ar_imm", 64'(a_out_imm), 64'd0);
        chk("ar_type", 64'(a_out_type), 64'd0);
        chk("ar_imm64", w_out_imm, 64'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("ar_post_valid", 64'(a_out_valid), 64'd0);
        chk("ar_post_rdy", 64'(a_in_ready), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
